// File: rtl/core_pkg.sv
// core_pkg: integer register file constants and address type shared by the core.
package core_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // One-hot register mask; x0 never appears in any mask.
   function automatic logic [NUM_REGS-1:0] reg_mask(input reg_addr_t a, input logic en);
      return (en && a != '0) ? (NUM_REGS'(1) << a) : '0;
   endfunction
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: register-file write port owner; merges ALU and long-unit results
// and stalls issue on hazards against outstanding long-latency writes.
module wb_scoreboard
   import core_pkg::*;
#(
   parameter int XLEN        = core_pkg::XLEN,
   parameter int MAX_PENDING = 4,
   localparam int CW         = $clog2(MAX_PENDING + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   input  logic            issue_long,
   input  reg_addr_t       issue_rd,
   input  reg_addr_t       issue_rs1,
   input  reg_addr_t       issue_rs2,
   output logic            issue_stall,
   input  logic            alu_valid,
   input  reg_addr_t       alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            long_valid,
   output logic            long_ready,
   input  reg_addr_t       long_rd,
   input  logic [XLEN-1:0] long_data,
   output logic            reg_write,
   output reg_addr_t       write_addr,
   output logic [XLEN-1:0] write_data,
   output logic [CW-1:0]   pend_cnt,
   output logic            sb_err
);
   localparam logic [CW-1:0] MAXC = CW'(MAX_PENDING);

   logic [NUM_REGS-1:0] r_pending;
   logic [CW-1:0]       r_pend_cnt;
   logic                r_reg_write;
   reg_addr_t           r_write_addr;
   logic [XLEN-1:0]     r_write_data;
   logic                r_sb_err;

   logic                w_hazard;
   logic                w_full;
   logic                w_set;
   logic                w_xfer;
   logic                w_clr;
   logic                w_inc;
   logic                w_dec;
   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_clr_mask;

   // Hazards are judged against the pending set as registered, before this cycle's updates.
   assign w_hazard    = r_pending[issue_rs1] | r_pending[issue_rs2] | r_pending[issue_rd];
   assign w_full      = r_pend_cnt >= MAXC;
   assign issue_stall = issue_valid & (w_hazard | (issue_long & (issue_rd != '0) & w_full));
   assign w_set       = issue_valid & ~issue_stall & issue_long;

   // ALU results cannot wait, so the long unit only gets the port when the ALU is idle.
   assign long_ready  = ~alu_valid;
   assign w_xfer      = long_valid & long_ready;
   assign w_clr       = w_xfer & r_pending[long_rd];

   assign w_set_mask  = reg_mask(issue_rd, w_set);
   assign w_clr_mask  = reg_mask(long_rd, w_clr);
   assign w_inc       = (w_set_mask != '0) & (r_pend_cnt != MAXC);
   assign w_dec       = w_clr & (r_pend_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending    <= '0;
         r_pend_cnt   <= '0;
         r_reg_write  <= 1'b0;
         r_write_addr <= '0;
         r_write_data <= '0;
         r_sb_err     <= 1'b0;
      end else begin
         r_pending    <= (r_pending | w_set_mask) & ~w_clr_mask & ~NUM_REGS'(1);
         r_pend_cnt   <= r_pend_cnt + CW'(w_inc) - CW'(w_dec);
         r_sb_err     <= r_sb_err | (w_xfer & ~w_clr);
         if (alu_valid) begin
            r_reg_write  <= alu_rd != '0;
            r_write_addr <= alu_rd;
            r_write_data <= alu_data;
         end else if (w_xfer) begin
            r_reg_write  <= long_rd != '0;
            r_write_addr <= long_rd;
            r_write_data <= long_data;
         end else begin
            r_reg_write  <= 1'b0;
         end
      end
   end

   assign reg_write  = r_reg_write;
   assign write_addr = r_write_addr;
   assign write_data = r_write_data;
   assign pend_cnt   = r_pend_cnt;
   assign sb_err     = r_sb_err;
endmodule
